// File: rtl/register_pipe.sv
// register_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing and flush.
// Define REG_PIPE_COUNT_EN to add the registered occupancy output 'count'.
module register_pipe #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef REG_PIPE_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    generate
        if (WIDTH < 1) begin : g_width_check
            $error("register_pipe: WIDTH must be >= 1");
        end
        if (DEPTH < 1) begin : g_depth_check
            $error("register_pipe: DEPTH must be >= 1");
        end
    endgenerate

    logic             valid_reg  [DEPTH];
    logic [WIDTH-1:0] data_reg   [DEPTH];
    logic             valid_next [DEPTH];
    logic             load       [DEPTH];
    logic [WIDTH-1:0] stage_in   [DEPTH];
    logic [DEPTH-1:0] advance;
    logic             accept;

    // Advance ripples back from the output stage, so a free slot anywhere
    // downstream lets every stage behind it move up in the same cycle.
    always_comb begin
        advance            = '0;
        advance[DEPTH-1]   = valid_reg[DEPTH-1] && out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            advance[i] = valid_reg[i] && (!valid_reg[i+1] || advance[i+1]);
        end
    end

    assign in_ready = !flush && (!valid_reg[0] || advance[0]);
    assign accept   = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign load[gi]     = accept;
                assign stage_in[gi] = in_data;
            end else begin : g_body
                // Flush must leave data untouched, so inter-stage loads are gated too.
                assign load[gi]     = advance[gi-1] && !flush;
                assign stage_in[gi] = data_reg[gi-1];
            end

            assign valid_next[gi] = flush         ? 1'b0 :
                                    load[gi]      ? 1'b1 :
                                    advance[gi]   ? 1'b0 :
                                                    valid_reg[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                end else begin
                    valid_reg[gi] <= valid_next[gi];
                    if (load[gi]) begin
                        data_reg[gi] <= stage_in[gi];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Counting the next-state valid bits keeps count aligned with the stages.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CW'(valid_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
`endif

endmodule

// File: tb/tb_register_pipe.sv
// tb_register_pipe: table-driven vectors plus a delivery scoreboard for register_pipe
// (WIDTH=64, DEPTH=4); count is checked when REG_PIPE_COUNT_EN is defined.
module tb_register_pipe;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef REG_PIPE_COUNT_EN
    logic [$clog2(DEPTH+1)-1:0] count;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb_q [$];

    typedef struct {
        bit               rst;
        bit               fl;
        bit               iv;
        logic [WIDTH-1:0] din;
        bit               ordy;
        int               e_ir;    // -1: not checked
        bit               e_ov;
        logic [WIDTH-1:0] e_od;
        bit               chk_od;
        int               e_cnt;   // -1: not checked
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    register_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef REG_PIPE_COUNT_EN
        ,
        .count    (count)
`endif
    );

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endfunction

    function automatic void v(bit rst, bit fl, bit iv, logic [63:0] din, bit ordy,
                              int e_ir, bit e_ov, logic [63:0] e_od, bit chk_od, int e_cnt);
        vec_t r;
        r.rst = rst; r.fl = fl; r.iv = iv; r.din = din; r.ordy = ordy;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od; r.chk_od = chk_od; r.e_cnt = e_cnt;
        vecs.push_back(r);
    endfunction

    task automatic drive(bit rst, bit fl, bit iv, logic [63:0] din, bit ordy);
        @(posedge clk);
        #1;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = din;
        out_ready = ordy;
    endtask

    // Scoreboard: accepted beats are queued, delivered beats must match in order.
    always @(negedge clk) begin
        logic [63:0] exp_d;
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got beat %h, required no beat", out_data);
                end else begin
                    exp_d = sb_q.pop_front();
                    if (out_data !== exp_d) begin
                        errors++;
                        $display("FAIL sb_order: got %h, required %h", out_data, exp_d);
                    end else begin
                        $display("deliver %h", out_data);
                    end
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
            end
        end
    end

    initial begin
        // Single beat latency and count profile.
        v(0,0,1,64'hA0,1, 1,0,64'h0,1,0);
        for (int k = 0; k < 3; k++) v(0,0,0,64'h0,1, 1,0,64'h0,0,1);
        v(0,0,0,64'h0,1, 1,1,64'hA0,1,1);
        v(0,0,0,64'h0,1, 1,0,64'h0,0,0);
        // Back-to-back stream 1..8 with no back-pressure.
        for (int n = 1; n <= 12; n++) begin
            int c;
            c = (n <= 4) ? n - 1 : ((n <= 9) ? 4 : 13 - n);
            v(0,0,(n <= 8),64'(n <= 8 ? n : 0),1, 1,(n >= 5),64'(n - 4),(n >= 5),c);
        end
        v(0,0,0,64'h0,1, 1,0,64'h0,0,0);
        // Fill against a stalled output, hold off a 5th beat, then drain.
        v(0,0,1,64'hAB,0,   1,0,64'h0,0,0);
        v(0,0,1,64'hCAB,0,  1,0,64'h0,0,1);
        v(0,0,1,64'h8CAB,0, 1,0,64'h0,0,2);
        v(0,0,1,64'hD,0,    1,0,64'h0,0,3);
        v(0,0,1,64'h55,0,   0,1,64'hAB,1,4);
        v(0,0,1,64'h55,0,   0,1,64'hAB,1,4);
        v(0,0,1,64'h55,1,   1,1,64'hAB,1,4);
        v(0,0,0,64'h0,1,    1,1,64'hCAB,1,4);
        v(0,0,0,64'h0,1,    1,1,64'h8CAB,1,3);
        v(0,0,0,64'h0,1,    1,1,64'hD,1,2);
        v(0,0,0,64'h0,1,    1,1,64'h55,1,1);
        v(0,0,0,64'h0,1,    1,0,64'h0,0,0);
        // Full pipe: simultaneous accept and deliver.
        for (int k = 0; k < 4; k++) v(0,0,1,64'(17 + k),0, 1,0,64'h0,0,k);
        v(0,0,1,64'hE,1, 1,1,64'h11,1,4);
        v(0,0,0,64'h0,0, 0,1,64'h12,1,4);
        // Drain to three beats, then flush with a beat on offer.
        v(0,0,0,64'h0,1,  1,1,64'h12,1,4);
        v(0,1,1,64'h99,0, 0,1,64'h13,1,3);
        v(0,0,0,64'h0,1,  1,0,64'h0,0,0);
        // Two beats held, reset with a beat on offer.
        v(0,0,1,64'h21,0, 1,0,64'h0,0,0);
        v(0,0,1,64'h22,0, 1,0,64'h0,0,1);
        v(1,0,1,64'h23,1, -1,0,64'h0,0,2);
        v(0,0,0,64'h0,1,  1,0,64'h0,1,0);
        for (int k = 0; k < 5; k++) v(0,0,0,64'h0,1, 1,0,64'h0,0,0);

        drive(1,0,0,64'h0,0);
        drive(1,0,0,64'h0,0);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].fl, vecs[k].iv, vecs[k].din, vecs[k].ordy);
            #3;
            if (vecs[k].e_ir >= 0)
                chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(vecs[k].e_ir));
            chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].e_ov));
            if (vecs[k].chk_od)
                chk($sformatf("v%0d_out_data", k), out_data, vecs[k].e_od);
`ifdef REG_PIPE_COUNT_EN
            if (vecs[k].e_cnt >= 0)
                chk($sformatf("v%0d_count", k), 64'(count), 64'(vecs[k].e_cnt));
`endif
            $display("vec %0d: in_ready=%0d out_valid=%0d out_data=%h",
                     k, in_ready, out_valid, out_data);
        end

        // Flush in the same cycle as an output handshake: that beat is delivered.
        drive(0,0,1,64'h31,0);
        drive(0,0,1,64'h32,0);
        drive(0,0,0,64'h0,0);
        drive(0,0,0,64'h0,0);
        drive(0,1,0,64'h0,1);
        #3;
        chk("flush_hs_out_valid", 64'(out_valid), 64'd1);
        chk("flush_hs_out_data", out_data, 64'h31);
        chk("flush_hs_in_ready", 64'(in_ready), 64'd0);
        drive(0,0,0,64'h0,1);
        #3;
        chk("post_flush_out_valid", 64'(out_valid), 64'd0);
        chk("post_flush_in_ready", 64'(in_ready), 64'd1);
`ifdef REG_PIPE_COUNT_EN
        chk("post_flush_count", 64'(count), 64'd0);
`endif

        // Random traffic with random back-pressure; the scoreboard checks order.
        for (int k = 0; k < 300; k++) begin
            drive(0, 0, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 3) != 0));
        end
        begin
            int budget;
            budget = 0;
            drive(0,0,0,64'h0,1);
            while ((out_valid || sb_q.size() != 0) && budget < 20) begin
                drive(0,0,0,64'h0,1);
                budget++;
            end
            #3;
            chk("drain_within_budget", 64'(budget < 20), 64'd1);
        end
        @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_pipe.md
REGISTER_PIPE -- requirements
Module: register_pipe

Interface
REQ-001 Parameter WIDTH, default 64, data bits per beat; SHALL be >= 1, checked by elaboration-time assertion.
REQ-002 Parameter DEPTH, default 4, number of register stages; SHALL be >= 1, checked by elaboration-time assertion.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 flush  input  1  synchronous discard of all held beats.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  pipe accepts a beat this cycle.
REQ-008 in_data  input  WIDTH  upstream beat payload.
REQ-009 out_valid  output  1  beat present at the output stage.
REQ-010 out_ready  input  1  downstream accepts the output beat.
REQ-011 out_data  output  WIDTH  output stage payload.
REQ-012 count  output  $clog2(DEPTH+1)  number of occupied stages; present only with REG_PIPE_COUNT_EN.

Function
REQ-013 Stages are numbered 0 (input) to DEPTH-1 (output); each stage holds a valid bit and a WIDTH-bit data register.
REQ-014 Stage i SHALL advance when it is valid and either (i = DEPTH-1 and out_ready = 1) or (i < DEPTH-1 and stage i+1 is empty or advancing).
REQ-015 in_ready SHALL equal !flush && (stage 0 empty || stage 0 advancing); it is combinational from out_ready through the chain.
REQ-016 A beat is accepted when in_valid && in_ready; on that edge stage 0 SHALL load in_data and set valid.
REQ-017 On an edge where stage i-1 advances, stage i SHALL load its data and set valid; where stage i advances and nothing enters it, stage i SHALL clear valid.
REQ-018 A data register SHALL change only when its stage loads; otherwise it holds, including when its valid bit is 0.
REQ-019 out_valid and out_data SHALL be driven directly from the valid and data registers of stage DEPTH-1.
REQ-020 Latency: a beat accepted on edge N with no back-pressure SHALL be presented at the output after edge N+DEPTH-1 (DEPTH=1: after edge N).
REQ-021 Throughput: with out_ready held at 1, one beat SHALL be accepted and one delivered every cycle, with no bubbles.
REQ-022 Bubbles: empty stages SHALL be collapsed; a stalled output SHALL not block acceptance while any stage is empty.
REQ-023 Full: when all DEPTH stages are valid and out_ready = 0, in_ready SHALL be 0 and all stage contents SHALL hold.
REQ-024 Full with out_ready = 1: in_ready SHALL be 1, allowing simultaneous accept and deliver.
REQ-025 Ordering: beats SHALL leave in acceptance order, with none duplicated or dropped except by flush or reset.
REQ-026 Flush on an edge SHALL clear every valid bit, accept no input, and leave data registers unchanged.
REQ-027 An output handshake during a flush cycle counts as delivered.

Reset
REQ-028 On a reset edge every valid bit SHALL clear, every data register SHALL clear to 0, and count SHALL clear to 0.
REQ-029 Reset SHALL take priority over flush and over any handshake; a beat offered in a reset cycle SHALL not be accepted.
REQ-030 Reset asserted mid-stream SHALL discard all held beats; the first edge after deassertion behaves as an empty pipe.

Configuration
REQ-031 Macro REG_PIPE_COUNT_EN defined: the count port SHALL exist as a register equal to the number of valid stages, updated on the same edge as the valid bits.
REQ-032 Macro REG_PIPE_COUNT_EN undefined: there SHALL be no count port and no count logic, and all other behaviour SHALL be identical.

Verification (WIDTH=64, DEPTH=4, REG_PIPE_COUNT_EN defined)
REQ-033 Reset, then in_valid=1 with in_data=64'hA0 for 1 cycle and out_ready=1 -> out_valid=1, out_data=64'hA0 after the 3rd edge following accept; count sequence 1,1,1,1,0.
REQ-034 Stream 64'h1..64'h8 on consecutive cycles with out_ready=1 -> in_ready stays 1 and outputs 1..8 appear on consecutive cycles in order.
REQ-035 out_ready=0, push 64'hAB, 64'hCAB, 64'h8CAB, 64'hD -> after the 4th accept in_ready=0 and count=4; a 5th beat is held off; out_ready=1 -> order AB, CAB, 8CAB, D, then the 5th beat.
REQ-036 Full pipe with out_ready=1 and in_valid=1 (64'hE) -> same-edge accept and deliver; count stays 4.
REQ-037 Pipe holding 3 beats, pulse flush with in_valid=1 -> count=0, out_valid=0, the offered beat is not accepted, and in_ready=1 on the next cycle.
REQ-038 Pipe holding 2 beats, assert reset with in_valid=1 -> all outputs 0 after the edge, and no held or offered beat ever appears at the output.
